// File: rtl/alu_status_unit_if.sv
// Bus between the 6502 ALU/decoder side (master) and alu_status_unit (slave).
interface alu_status_unit_if #(parameter int WIDTH = 8);
    logic             alu_wout;
    logic [WIDTH-1:0] alu_add;
    logic             alu_carry;
    logic             alu_half_carry;
    logic             alu_overflow;
    logic             op_sum;
    logic             op_sub;
    logic             upd_nz;
    logic [2:0]       flag_op;
    logic             p_load;
    logic [WIDTH-1:0] p_din;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [WIDTH-1:0] status;
    logic             carry_in;
    logic             dec_mode;

    modport master (
        output alu_wout, alu_add, alu_carry, alu_half_carry, alu_overflow,
               op_sum, op_sub, upd_nz, flag_op, p_load, p_din,
        input  result, result_valid, status, carry_in, dec_mode
    );

    modport slave (
        input  alu_wout, alu_add, alu_carry, alu_half_carry, alu_overflow,
               op_sum, op_sub, upd_nz, flag_op, p_load, p_din,
        output result, result_valid, status, carry_in, dec_mode
    );
endinterface

// File: rtl/alu_status_unit.sv
// 6502 ALU result capture, BCD adjust and P register (N V - B D I Z C).
// Define ALU_DECIMAL_EN to build the decimal adjust; otherwise 2A03 behaviour.
module alu_status_unit #(
    parameter int WIDTH = 8
) (
    input  logic              phi1,
    input  logic              reset_n,
    alu_status_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        FLAG_NOP = 3'd0,
        FLAG_SEC = 3'd1,
        FLAG_CLC = 3'd2,
        FLAG_SEI = 3'd3,
        FLAG_CLI = 3'd4,
        FLAG_SED = 3'd5,
        FLAG_CLD = 3'd6,
        FLAG_CLV = 3'd7
    } flag_op_e;

    localparam logic [WIDTH-1:0] STATUS_RESET = 8'h24;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_add_q;
    logic             s1_carry_q;
    logic             s1_ovf_q;
    logic             s1_sum_q;
    logic             s1_nz_q;
`ifdef ALU_DECIMAL_EN
    logic             s1_hc_q;
    logic             s1_sub_q;
`endif

    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] adj_d;
    logic             adj_carry_d;

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_add_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_ovf_q   <= 1'b0;
            s1_sum_q   <= 1'b0;
            s1_nz_q    <= 1'b0;
`ifdef ALU_DECIMAL_EN
            s1_hc_q    <= 1'b0;
            s1_sub_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q <= bus.alu_wout;
            if (bus.alu_wout) begin
                s1_add_q   <= bus.alu_add;
                s1_carry_q <= bus.alu_carry;
                s1_ovf_q   <= bus.alu_overflow;
                s1_sum_q   <= bus.op_sum;
                s1_nz_q    <= bus.upd_nz;
`ifdef ALU_DECIMAL_EN
                s1_hc_q    <= bus.alu_half_carry;
                s1_sub_q   <= bus.op_sub;
`endif
            end
        end
    end

    // The hi-nibble test of the add path deliberately sees the lo-nibble correction.
    always_comb begin
        adj_d       = s1_add_q;
        adj_carry_d = s1_carry_q;
`ifdef ALU_DECIMAL_EN
        if (s1_sum_q && status_q[3]) begin
            if (s1_sub_q) begin
                if (!s1_hc_q)
                    adj_d = adj_d - 8'h06;
                if (!s1_carry_q)
                    adj_d = adj_d - 8'h60;
            end else begin
                if (s1_hc_q || (adj_d[3:0] > 4'd9))
                    adj_d = adj_d + 8'h06;
                if (s1_carry_q || (adj_d[7:4] > 4'd9)) begin
                    adj_d       = adj_d + 8'h60;
                    adj_carry_d = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        status_d       = status_q;
        result_d       = result_q;
        result_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            result_d = adj_d;
            if (s1_nz_q) begin
                status_d[7] = adj_d[7];
                status_d[1] = (adj_d == '0);
            end
            if (s1_sum_q) begin
                status_d[0] = adj_carry_d;
                status_d[6] = s1_ovf_q;
            end
        end
        // Explicit flag ops override the commit for their own bit only.
        case (flag_op_e'(bus.flag_op))
            FLAG_SEC: status_d[0] = 1'b1;
            FLAG_CLC: status_d[0] = 1'b0;
            FLAG_SEI: status_d[2] = 1'b1;
            FLAG_CLI: status_d[2] = 1'b0;
            FLAG_SED: status_d[3] = 1'b1;
            FLAG_CLD: status_d[3] = 1'b0;
            FLAG_CLV: status_d[6] = 1'b0;
            default:  ;
        endcase
        if (bus.p_load)
            status_d = bus.p_din;
        status_d[5] = 1'b1;
        status_d[4] = 1'b0;
    end

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            status_q       <= STATUS_RESET;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            status_q       <= status_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.status       = status_q;
    assign bus.carry_in     = status_q[0];
    assign bus.dec_mode     = status_q[3];

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit; expectations follow ALU_DECIMAL_EN.
module tb_alu_status_unit;

    localparam logic [2:0] NOP = 3'd0, SEC = 3'd1, CLC = 3'd2, SEI = 3'd3,
                           CLI = 3'd4, SED = 3'd5, CLD = 3'd6, CLV = 3'd7;

    logic phi1;
    logic reset_n;
    int   checks;
    int   errors;

    alu_status_unit_if bus();

    alu_status_unit dut (
        .phi1    (phi1),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    typedef struct {
        string      name;
        logic [7:0] startP;
        logic [7:0] add;
        logic       carry;
        logic       hc;
        logic       ovf;
        logic       sum;
        logic       sub;
        logic       nz;
        logic [7:0] resDec;
        logic [7:0] statDec;
        logic [7:0] resBin;
        logic [7:0] statBin;
    } vec_t;

    typedef struct {
        logic       pload;
        logic [7:0] pdin;
        logic [2:0] fop;
        logic [7:0] expStat;
    } flag_vec_t;

    vec_t      vecs[9];
    flag_vec_t fvecs[9];

    task automatic applyStimulus(input logic wout, input logic [7:0] add,
                                 input logic carry, input logic hc, input logic ovf,
                                 input logic sum, input logic sub, input logic nz,
                                 input logic [2:0] fop, input logic pload,
                                 input logic [7:0] pdin);
        bus.alu_wout       = wout;
        bus.alu_add        = add;
        bus.alu_carry      = carry;
        bus.alu_half_carry = hc;
        bus.alu_overflow   = ovf;
        bus.op_sum         = sum;
        bus.op_sub         = sub;
        bus.upd_nz         = nz;
        bus.flag_op        = fop;
        bus.p_load         = pload;
        bus.p_din          = pdin;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b0, 8'h00);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
        end
    endtask

    initial begin
        logic [7:0] expRes;
        logic [7:0] expStat;
        checks = 0;
        errors = 0;

        // name, startP, add, c, hc, v, sum, sub, nz, resDec, statDec, resBin, statBin
        vecs[0] = '{"adc_bin",      8'h24, 8'h00, 1, 0, 1, 1, 0, 1, 8'h00, 8'h67, 8'h00, 8'h67};
        vecs[1] = '{"lda_nz_only",  8'h24, 8'h80, 1, 0, 1, 0, 0, 1, 8'h80, 8'hA4, 8'h80, 8'hA4};
        vecs[2] = '{"adc_dec_9a",   8'h2C, 8'h9A, 0, 0, 0, 1, 0, 1, 8'h00, 8'h2F, 8'h9A, 8'hAC};
        vecs[3] = '{"sbc_dec_f9",   8'h2D, 8'hF9, 0, 1, 0, 1, 1, 1, 8'h99, 8'hAC, 8'hF9, 8'hAC};
        vecs[4] = '{"adc_dec_hc",   8'h2C, 8'h10, 0, 1, 0, 1, 0, 1, 8'h16, 8'h2C, 8'h10, 8'h2C};
        vecs[5] = '{"adc_dec_cy",   8'h2C, 8'h20, 1, 0, 1, 1, 0, 1, 8'h80, 8'hED, 8'h20, 8'h6D};
        vecs[6] = '{"sbc_dec_both", 8'h2D, 8'hEF, 0, 0, 0, 1, 1, 1, 8'h89, 8'hAC, 8'hEF, 8'hAC};
        vecs[7] = '{"dec_no_sum",   8'h2F, 8'h9A, 0, 0, 0, 0, 0, 1, 8'h9A, 8'hAD, 8'h9A, 8'hAD};
        vecs[8] = '{"sum_no_nz",    8'hE6, 8'h55, 0, 0, 0, 1, 0, 0, 8'h55, 8'hA6, 8'h55, 8'hA6};

        fvecs[0] = '{1'b0, 8'h00, SEC, 8'h25};
        fvecs[1] = '{1'b0, 8'h00, SED, 8'h2D};
        fvecs[2] = '{1'b0, 8'h00, CLI, 8'h29};
        fvecs[3] = '{1'b0, 8'h00, SEI, 8'h2D};
        fvecs[4] = '{1'b0, 8'h00, CLC, 8'h2C};
        fvecs[5] = '{1'b0, 8'h00, CLD, 8'h24};
        fvecs[6] = '{1'b1, 8'h64, NOP, 8'h64};
        fvecs[7] = '{1'b0, 8'h00, CLV, 8'h24};
        fvecs[8] = '{1'b1, 8'h10, NOP, 8'h20};

        // Reset held for two edges while the ALU keeps offering results.
        reset_n = 1'b0;
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        @(negedge phi1);
        checkOutput("rst_result", bus.result, 8'h00);
        checkOutput("rst_valid", {7'd0, bus.result_valid}, 8'h00);
        checkOutput("rst_status", bus.status, 8'h24);
        checkOutput("rst_carry_in", {7'd0, bus.carry_in}, 8'h00);
        checkOutput("rst_dec_mode", {7'd0, bus.dec_mode}, 8'h00);
        reset_n = 1'b1;
        idle();
        @(negedge phi1);
        checkOutput("rst_release_valid", {7'd0, bus.result_valid}, 8'h00);

        for (int i = 0; i < 9; i++) begin
`ifdef ALU_DECIMAL_EN
            expRes  = vecs[i].resDec;
            expStat = vecs[i].statDec;
`else
            expRes  = vecs[i].resBin;
            expStat = vecs[i].statBin;
`endif
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b1, vecs[i].startP);
            @(negedge phi1);
            applyStimulus(1'b1, vecs[i].add, vecs[i].carry, vecs[i].hc, vecs[i].ovf,
                          vecs[i].sum, vecs[i].sub, vecs[i].nz, NOP, 1'b0, 8'h00);
            @(negedge phi1);
            checkOutput({vecs[i].name, "_s1_valid"}, {7'd0, bus.result_valid}, 8'h00);
            idle();
            @(negedge phi1);
            checkOutput({vecs[i].name, "_result"}, bus.result, expRes);
            checkOutput({vecs[i].name, "_valid"}, {7'd0, bus.result_valid}, 8'h01);
            checkOutput({vecs[i].name, "_status"}, bus.status, expStat);
            checkOutput({vecs[i].name, "_carry_in"}, {7'd0, bus.carry_in}, {7'd0, expStat[0]});
            checkOutput({vecs[i].name, "_dec_mode"}, {7'd0, bus.dec_mode}, {7'd0, expStat[3]});
            @(negedge phi1);
            checkOutput({vecs[i].name, "_pulse_end"}, {7'd0, bus.result_valid}, 8'h00);
            checkOutput({vecs[i].name, "_hold"}, bus.result, expRes);
        end

        // Explicit flag ops and PLP loads, one per edge.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 8'h24);
        @(negedge phi1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          fvecs[i].fop, fvecs[i].pload, fvecs[i].pdin);
            @(negedge phi1);
            checkOutput($sformatf("flag_%0d_status", i), bus.status, fvecs[i].expStat);
            checkOutput($sformatf("flag_%0d_carry_in", i), {7'd0, bus.carry_in}, {7'd0, fvecs[i].expStat[0]});
            checkOutput($sformatf("flag_%0d_dec_mode", i), {7'd0, bus.dec_mode}, {7'd0, fvecs[i].expStat[3]});
        end

        // CLC on the commit edge beats the committed C=1; N/Z still land.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 8'h24);
        @(negedge phi1);
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CLC, 1'b0, 8'h00);
        @(negedge phi1);
        checkOutput("prio_clc_status", bus.status, 8'hA4);
        checkOutput("prio_clc_result", bus.result, 8'h80);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEC, 1'b1, 8'hFF);
        @(negedge phi1);
        checkOutput("prio_pload_status", bus.status, 8'hEF);

        // PLP on a commit edge overrides the committed flags but not the result.
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 8'h24);
        @(negedge phi1);
        checkOutput("prio_plp_commit_status", bus.status, 8'h24);
        checkOutput("prio_plp_commit_valid", {7'd0, bus.result_valid}, 8'h01);
        checkOutput("prio_plp_commit_result", bus.result, 8'h00);

        // Back-to-back results stream out in order.
        idle();
        @(negedge phi1);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        checkOutput("stream_lat_valid", {7'd0, bus.result_valid}, 8'h00);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        checkOutput("stream_0_valid", {7'd0, bus.result_valid}, 8'h01);
        checkOutput("stream_0_result", bus.result, 8'h01);
        applyStimulus(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        checkOutput("stream_1_valid", {7'd0, bus.result_valid}, 8'h01);
        checkOutput("stream_1_result", bus.result, 8'h02);
        idle();
        @(negedge phi1);
        checkOutput("stream_2_valid", {7'd0, bus.result_valid}, 8'h01);
        checkOutput("stream_2_result", bus.result, 8'h03);
        @(negedge phi1);
        checkOutput("stream_end_valid", {7'd0, bus.result_valid}, 8'h00);
        checkOutput("stream_end_status", bus.status, 8'h24);

        // Reset one edge after a capture discards the in-flight result.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 1'b1, 8'hFF);
        @(negedge phi1);
        applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        reset_n = 1'b0;
        applyStimulus(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 1'b0, 8'h00);
        @(negedge phi1);
        reset_n = 1'b1;
        idle();
        @(negedge phi1);
        checkOutput("midrst_valid", {7'd0, bus.result_valid}, 8'h00);
        checkOutput("midrst_status", bus.status, 8'h24);
        checkOutput("midrst_result", bus.result, 8'h00);
        @(negedge phi1);
        checkOutput("midrst_valid_late", {7'd0, bus.result_valid}, 8'h00);
        checkOutput("midrst_status_late", bus.status, 8'h24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_status_unit.md
Name: alu_status_unit

Overview:
- Downstream stage of the 6502 ALU.
- Captures the ALU hold-register result whenever the ALU asserts wout, applies BCD decimal adjust when P.D is set and the op is SUM, then registers the final result.
- Maintains the processor status register P (N V - B D I Z C), including explicit flag ops (SEC/CLC/SEI/CLI/SED/CLD/CLV) and PLP-style load.
- Drives carry_in and dec_mode back to the ALU.

Parameters:
- WIDTH, `REG_WIDTH (8): data and status width. Only 8 is supported.

Ports:
- phi1  in  1  clock; all state updates on posedge phi1
- reset_n  in  1  synchronous, active-low reset, sampled on posedge phi1
- alu_wout  in  1  ALU result valid this cycle
- alu_add  in  WIDTH  ALU hold-register result
- alu_carry  in  1  ALU carry_out
- alu_half_carry  in  1  ALU carry out of bit 3
- alu_overflow  in  1  ALU signed overflow
- op_sum  in  1  result came from `SUM (enables C/V update and decimal adjust)
- op_sub  in  1  SUM was a subtract (SBC; B pre-inverted upstream)
- upd_nz  in  1  update N and Z from the final result
- flag_op  in  3  0 NOP, 1 SEC, 2 CLC, 3 SEI, 4 CLI, 5 SED, 6 CLD, 7 CLV
- p_load  in  1  load P from p_din
- p_din  in  WIDTH  PLP data
- result  out  WIDTH  final (adjusted) result
- result_valid  out  1  one-cycle pulse: result is new
- status  out  WIDTH  P register
- carry_in  out  1  equals status[0], feeds the ALU
- dec_mode  out  1  equals status[3], feeds the ALU

Behaviour:
- Reset (reset_n=0 at an edge):
  - result=0x00, result_valid=0, status=0x24 (I=1, bit5=1).
  - Both pipeline valid bits cleared. In-flight results are discarded and produce no result_valid and no flag write.
- Pipeline: two registered stages, s1 (capture) and s2 (adjust/commit). A new result is accepted every cycle; there is no stall and no backpressure.
  - Edge k: alu_wout=1 latches alu_add, alu_carry, alu_half_carry, alu_overflow, op_sum, op_sub, upd_nz into s1. s1_valid=1.
  - Edge k+1: s2 computes the adjusted result and registers it to result. result_valid=1 for exactly one cycle and status flags are committed. Latency is therefore 2 edges.
  - Back-to-back wout gives back-to-back result_valid, in order.
- Decimal adjust (s2; only when op_sum=1, status[3]=1 at the s2 edge, and the feature is enabled):
  - Add: if half_carry or lo nibble>9, add 0x06. Then, using the updated value, if carry or hi nibble>9, add 0x60 and set C=1. Otherwise C=alu_carry. All arithmetic is mod 256.
  - Subtract: if half_carry=0, subtract 0x06. If carry=0, subtract 0x60. C=alu_carry.
  - No adjust in any other case: result=alu_add, C=alu_carry.
- Flag commit at the s2 edge:
  - if upd_nz: N=result[7], Z=(result==0), both taken from the adjusted value.
  - if op_sum: C as above, V=alu_overflow (binary, not adjusted).
  - Flags not selected keep their value.
- Priority when several events land on one edge: reset > p_load > flag_op > s2 commit.
  - p_load: status = p_din with bit5 forced to 1 and bit4 forced to 0. It overrides flag_op and the commit. result/result_valid still update normally.
  - flag_op: sets or clears its single bit. It wins over the commit for that bit only; all other commit bits still apply.
- status[5] is always 1 and status[4] is always 0.
- carry_in and dec_mode are combinational copies of status bits, so they change the cycle after the edge that writes them.
- Inputs other than p_load/flag_op are ignored when alu_wout=0. result holds its value between pulses.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- Defined: decimal adjust works as specified above.
- Undefined (2A03 behaviour):
  - D is still set, cleared and loaded, and dec_mode still follows it.
  - No decimal adjust is applied: result=alu_add, C=alu_carry.
  - No adjust logic is synthesized.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with alu_wout=1 -> result=0x00, result_valid=0, status=0x24, carry_in=0, dec_mode=0.
- Binary ADC: alu_add=0x00, alu_carry=1, alu_overflow=1, op_sum=1, upd_nz=1 -> 2 edges later result=0x00, result_valid pulses once, status=0x67.
- Decimal add: SED first (status=0x2C), then alu_add=0x9A, carry=0, half_carry=0, op_sum=1, upd_nz=1 -> with ALU_DECIMAL_EN, result=0x00 and status=0x2F. Without the macro, result=0x9A and status=0xAC.
- Decimal subtract: D=1, alu_add=0xF9, carry=0, half_carry=1, op_sub=1 -> result=0x99, C=0, N=1.
- Priority: flag_op=CLC on the same edge that commits C=1 -> C=0, N/Z still committed. Then p_load=1, p_din=0xFF together with flag_op=SEC -> status=0xEF.
- Streaming and reset mid-flight: alu_wout on 3 consecutive edges with 0x01, 0x02, 0x03 -> result_valid high 3 consecutive cycles with results in order. Repeat with reset_n=0 one edge after the first capture -> no result_valid and status=0x24.
